// File: rtl/gamepad_button_viz_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gamepad_button_viz_pkg : button indices, colours, glyph ROM, glyph positions
// rev 1.0
// -----------------------------------------------------------------------------
package gamepad_button_viz_pkg;

  localparam int NUM_BTNS = 12;

  // Index = bit position inside a pad's 12-bit button field
  localparam int BTN_R      = 0;
  localparam int BTN_L      = 1;
  localparam int BTN_X      = 2;
  localparam int BTN_A      = 3;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_UP     = 7;
  localparam int BTN_START  = 8;
  localparam int BTN_SELECT = 9;
  localparam int BTN_Y      = 10;
  localparam int BTN_B      = 11;

  typedef logic [5:0] rgb_t;

  localparam rgb_t COL_BLACK = 6'b000000;
  localparam rgb_t COL_GREEN = 6'b001100;
  localparam rgb_t COL_CYAN  = 6'b001111;
  localparam rgb_t COL_AMBER = 6'b011000;
  localparam rgb_t COL_WHITE = 6'b111111;

  // Row r occupies bits [63-8r -: 8]; bit 7 of a row is the leftmost pixel
  localparam logic [63:0] GLYPH_ROM [NUM_BTNS] = '{
    64'h7C66667C786C6600,   // R
    64'h6060606060607E00,   // L
    64'h66663C183C666600,   // X
    64'h3C66667E66666600,   // A
    64'h080C0EFFFF0E0C08,   // RIGHT
    64'h103070FFFF703010,   // LEFT
    64'h181818FF7E3C1800,   // DOWN
    64'h183C7EFF18181800,   // UP
    64'h002030383C383020,   // START
    64'h00007E7E7E7E0000,   // SELECT
    64'h6666663C18181800,   // Y
    64'h7C66667C66667C00    // B
  };

  localparam logic [10:0] BASE_X [NUM_BTNS] = '{
    11'd592, 11'd32,  11'd512, 11'd544, 11'd128, 11'd64,
    11'd96,  11'd96,  11'd328, 11'd264, 11'd480, 11'd512
  };

  localparam logic [10:0] BASE_Y [NUM_BTNS] = '{
    11'd100, 11'd100, 11'd200, 11'd240, 11'd240, 11'd240,
    11'd280, 11'd200, 11'd240, 11'd240, 11'd240, 11'd280
  };

  // row/col_off are unscaled glyph coordinates; col_off 0 is the left edge
  function automatic logic glyph_bit(input logic [3:0] btn,
                                     input logic [2:0] row,
                                     input logic [2:0] col_off);
    logic [7:0] line;
    line = GLYPH_ROM[btn][{~row, 3'b111} -: 8];
    return line[~col_off];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gamepad_button_viz_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gamepad_button_viz_if : video timing in, overlay colour and delayed syncs out
// rev 1.0
// -----------------------------------------------------------------------------
interface gamepad_button_viz_if;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_active;
  logic       hsync_in;
  logic       vsync_in;
  logic [5:0] rgb;
  logic       hsync_out;
  logic       vsync_out;

  modport master (
    output pix_x, pix_y, video_active, hsync_in, vsync_in,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  pix_x, pix_y, video_active, hsync_in, vsync_in,
    output rgb, hsync_out, vsync_out
  );
endinterface
`default_nettype wire

// File: rtl/gamepad_button_viz_afterglow_ctr.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gamepad_afterglow_ctr : per-button frame counter running after a release
// rev 1.0
// -----------------------------------------------------------------------------
module gamepad_afterglow_ctr #(
  parameter int HOLD_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       snap_old,
  input  logic       snap_new,
  output logic [5:0] count
);
  logic [5:0] count_q;
  logic [5:0] count_d;

  always_comb begin
    count_d = count_q;
    if (frame_tick) begin
      if (snap_old && !snap_new) begin
        count_d = 6'(HOLD_FRAMES);
      end else if (snap_new) begin
        count_d = 6'd0;
      end else if (count_q != 6'd0) begin
        count_d = count_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 6'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule
`default_nettype wire

// File: rtl/gamepad_button_viz.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gamepad_button_viz : per-frame button snapshot rendered as glyphs, 2-cycle pipe
// rev 1.0
// -----------------------------------------------------------------------------
module gamepad_button_viz
  import gamepad_button_viz_pkg::*;
#(
  parameter int NUM_PADS    = 1,
  parameter int SCALE_LOG2  = 1,
  parameter int HOLD_FRAMES = 15,
  parameter int PAD_Y_STEP  = 160
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gamepad_button_viz_if.slave    vid,
  input  logic [12*NUM_PADS-1:0] buttons
);
  localparam int          NUM_BUTTONS = NUM_BTNS * NUM_PADS;
  localparam int          IDX_W       = $clog2(NUM_BUTTONS);
  localparam logic [10:0] GLYPH_SIZE  = 11'(8 << SCALE_LOG2);

  logic                   vs_q, vs_d;
  logic                   vs_prev_q, vs_prev_d;
  logic                   frame_tick;
  logic [NUM_BUTTONS-1:0] snapshot_q, snapshot_d;
  logic [5:0]             glow_count [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] hit_vec;
  logic [10:0]            px, py;
  logic                   hit_q, hit_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [1:0]             sync1_q, sync1_d;
  logic [1:0]             sync2_q, sync2_d;
  rgb_t                   rgb_q, rgb_d;

  // Both vsync history flops reset low so a reset can never fabricate an edge
  always_comb begin
    vs_d       = vid.vsync_in;
    vs_prev_d  = vs_q;
    frame_tick = vs_prev_q & ~vs_q;
    snapshot_d = frame_tick ? buttons : snapshot_q;
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_glow
    gamepad_afterglow_ctr #(
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .snap_old   (snapshot_q[i]),
      .snap_new   (buttons[i]),
      .count      (glow_count[i])
    );
  end

  assign px = {1'b0, vid.pix_x};
  assign py = {1'b0, vid.pix_y};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_hit
    localparam int          BTN = i % NUM_BTNS;
    localparam int          PAD = i / NUM_BTNS;
    localparam logic [10:0] GX  = BASE_X[BTN];
    localparam logic [10:0] GY  = 11'(int'(BASE_Y[BTN]) + PAD * PAD_Y_STEP);
    logic [10:0] dx, dy;
    logic        in_box;

    assign dx     = px - GX;
    assign dy     = py - GY;
    assign in_box = (px >= GX) && (px < GX + GLYPH_SIZE) &&
                    (py >= GY) && (py < GY + GLYPH_SIZE);
    assign hit_vec[i] = in_box &&
                        glyph_bit(4'(BTN), 3'(dy >> SCALE_LOG2), 3'(dx >> SCALE_LOG2));
  end

  // Descending scan so the lowest flat index is written last and wins
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_d = 1'b1;
        idx_d = IDX_W'(i);
      end
    end
    hit_d   = hit_d & vid.video_active;
    sync1_d = {vid.hsync_in, vid.vsync_in};
  end

  always_comb begin
    rgb_d   = COL_BLACK;
    sync2_d = sync1_q;
    if (hit_q) begin
      if (snapshot_q[idx_q]) begin
        rgb_d = (int'(idx_q) >= NUM_BTNS) ? COL_CYAN : COL_GREEN;
      end else if (glow_count[idx_q] != 6'd0) begin
        rgb_d = COL_AMBER;
      end else begin
        rgb_d = COL_WHITE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
      snapshot_q <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      rgb_q      <= COL_BLACK;
    end else begin
      vs_q       <= vs_d;
      vs_prev_q  <= vs_prev_d;
      snapshot_q <= snapshot_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rgb_q      <= rgb_d;
    end
  end

  assign vid.rgb       = rgb_q;
  assign vid.hsync_out = sync2_q[1];
  assign vid.vsync_out = sync2_q[0];
endmodule
`default_nettype wire

// File: tb/tb_gamepad_button_viz.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_gamepad_button_viz : vector table, corner sequences and random model check
// rev 1.0
// -----------------------------------------------------------------------------
module tb_gamepad_button_viz;
  import gamepad_button_viz_pkg::GLYPH_ROM;

  localparam int NUM_PADS    = 2;
  localparam int SCALE_LOG2  = 1;
  localparam int HOLD_FRAMES = 3;
  localparam int PAD_Y_STEP  = 160;
  localparam int NB          = 24;
  localparam int GSZ         = 8 << SCALE_LOG2;

  localparam logic [5:0] BLACK = 6'b000000;
  localparam logic [5:0] GREEN = 6'b001100;
  localparam logic [5:0] CYAN  = 6'b001111;
  localparam logic [5:0] AMBER = 6'b011000;
  localparam logic [5:0] WHITE = 6'b111111;

  // Glyph positions by bit: r, l, x, a, right, left, down, up, start, select, y, b
  int bx [12] = '{592, 32, 512, 544, 128, 64, 96, 96, 328, 264, 480, 512};
  int by [12] = '{100, 100, 200, 240, 240, 240, 280, 200, 240, 240, 240, 280};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] buttons = '0;

  gamepad_button_viz_if vif();

  gamepad_button_viz #(
    .NUM_PADS    (NUM_PADS),
    .SCALE_LOG2  (SCALE_LOG2),
    .HOLD_FRAMES (HOLD_FRAMES),
    .PAD_Y_STEP  (PAD_Y_STEP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vid     (vif),
    .buttons (buttons)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit snap [NB];
  int glow [NB];

  typedef struct {
    int px;
    int py;
    bit va;
    bit hs;
    bit vs;
    bit chk;
    bit valid;
  } pent_t;
  pent_t p0, p1;

  typedef struct {
    logic [NB-1:0] btn;
    int            px;
    int            py;
    bit            va;
    logic [5:0]    exp;
  } vec_t;
  vec_t tbl [11];

  function automatic vec_t mk(input logic [NB-1:0] btn, input int px, input int py,
                              input bit va, input logic [5:0] exp);
    vec_t v;
    v.btn = btn; v.px = px; v.py = py; v.va = va; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] exp_rgb(input int px, input int py, input bit va);
    logic [63:0] g;
    logic [7:0]  line;
    int b, p, x, y, row, col;
    if (!va) return BLACK;
    for (int i = 0; i < NB; i++) begin
      b = i % 12;
      p = i / 12;
      x = bx[b];
      y = by[b] + p * PAD_Y_STEP;
      if (px >= x && px < x + GSZ && py >= y && py < y + GSZ) begin
        row  = (py - y) / (1 << SCALE_LOG2);
        col  = 7 - (px - x) / (1 << SCALE_LOG2);
        g    = GLYPH_ROM[b];
        line = g[63 - 8 * row -: 8];
        if (line[col]) begin
          if (snap[i]) return (p == 1) ? CYAN : GREEN;
          if (glow[i] != 0) return AMBER;
          return WHITE;
        end
      end
    end
    return BLACK;
  endfunction

  task automatic check(input string what, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", what, act, exp);
    end
  endtask

  // One clock: check the entry driven two steps ago, then drive a new one
  task automatic step(input int px, input int py, input bit va, input bit hs,
                      input bit vs, input bit chk, input bit vld);
    @(posedge clk);
    #1;
    if (p1.valid) begin
      check($sformatf("syncs@(%0d,%0d)", p1.px, p1.py),
            {4'b0, vif.hsync_out, vif.vsync_out}, {4'b0, p1.hs, p1.vs});
      if (p1.chk)
        check($sformatf("model rgb@(%0d,%0d) va=%0b", p1.px, p1.py, p1.va),
              vif.rgb, exp_rgb(p1.px, p1.py, p1.va));
    end
    p1 = p0;
    p0.px = px; p0.py = py; p0.va = va; p0.hs = hs; p0.vs = vs;
    p0.chk = chk; p0.valid = vld;
    vif.pix_x        = 10'(px);
    vif.pix_y        = 10'(py);
    vif.video_active = va;
    vif.hsync_in     = hs;
    vif.vsync_in     = vs;
  endtask

  task automatic pix_expect(input string name, input int px, input int py, input bit va,
                            input bit vs, input logic [5:0] exp);
    step(px, py, va, 1'b1, vs, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1, vs, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1, vs, 1'b0, 1'b1);
    check(name, vif.rgb, exp);
  endtask

  task automatic frame(input logic [NB-1:0] nb);
    buttons = nb;
    repeat (2) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NB; i++) begin
      if (snap[i] && !nb[i])  glow[i] = HOLD_FRAMES;
      else if (nb[i])         glow[i] = 0;
      else if (glow[i] > 0)   glow[i] = glow[i] - 1;
      snap[i] = nb[i];
    end
  endtask

  // Syncs held low and a lit pixel driven so reset values are distinguishable
  task automatic do_reset();
    p0.valid = 1'b0;
    p1.valid = 1'b0;
    rst_n = 1'b0;
    repeat (4) step(548, 246, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset rgb", vif.rgb, BLACK);
    check("reset hsync_out", {5'b0, vif.hsync_out}, 6'd1);
    check("reset vsync_out", {5'b0, vif.vsync_out}, 6'd1);
    for (int i = 0; i < NB; i++) begin
      snap[i] = 1'b0;
      glow[i] = 0;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int px, py, g;
    vif.pix_x = '0; vif.pix_y = '0; vif.video_active = 1'b0;
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
    p0.valid = 1'b0; p1.valid = 1'b0;

    do_reset();
    pix_expect("post-reset A white", 548, 246, 1'b1, 1'b1, WHITE);

    tbl[0]  = mk(24'h000008, 548, 246, 1'b1, GREEN);
    tbl[1]  = mk(24'h000000, 548, 246, 1'b1, WHITE);
    tbl[2]  = mk(24'h100000, 336, 408, 1'b1, CYAN);
    tbl[3]  = mk(24'h100000, 336, 248, 1'b1, WHITE);
    tbl[4]  = mk(24'h000008, 548, 246, 1'b0, BLACK);
    tbl[5]  = mk(24'h000008, 560, 240, 1'b1, BLACK);
    tbl[6]  = mk(24'h000008, 543, 240, 1'b1, BLACK);
    tbl[7]  = mk(24'h008000, 548, 406, 1'b1, CYAN);
    tbl[8]  = mk(24'hFFFFFF, 548, 246, 1'b1, GREEN);
    tbl[9]  = mk(24'hFFFFFF, 104, 368, 1'b1, CYAN);
    tbl[10] = mk(24'h000000, 544, 240, 1'b1, BLACK);
    for (int v = 0; v < 11; v++) begin
      repeat (HOLD_FRAMES + 1) frame(tbl[v].btn);
      pix_expect($sformatf("vector %0d", v), tbl[v].px, tbl[v].py, tbl[v].va, 1'b1, tbl[v].exp);
    end

    // Afterglow on UP, then re-press during the glow
    frame(24'h000080);
    pix_expect("up pressed", 104, 208, 1'b1, 1'b1, GREEN);
    for (int f = 1; f <= 3; f++) begin
      frame(24'h0);
      pix_expect($sformatf("up glow frame %0d", f), 104, 208, 1'b1, 1'b1, AMBER);
    end
    frame(24'h0);
    pix_expect("up glow expired", 104, 208, 1'b1, 1'b1, WHITE);
    frame(24'h000080);
    frame(24'h0);
    pix_expect("up glow again", 104, 208, 1'b1, 1'b1, AMBER);
    frame(24'h000080);
    pix_expect("up re-pressed", 104, 208, 1'b1, 1'b1, GREEN);
    for (int f = 1; f <= 3; f++) frame(24'h0);
    pix_expect("up reload 3rd frame", 104, 208, 1'b1, 1'b1, AMBER);
    frame(24'h0);
    pix_expect("up reload expired", 104, 208, 1'b1, 1'b1, WHITE);

    // Mid-frame button changes must not reach the screen
    frame(24'h000008);
    buttons = 24'h000000;
    pix_expect("no tear A", 548, 246, 1'b1, 1'b1, GREEN);
    buttons = 24'hFFFFFF;
    pix_expect("no tear start", 336, 248, 1'b1, 1'b1, WHITE);
    pix_expect("no tear pad1 A", 548, 406, 1'b1, 1'b1, WHITE);

    // Reset clears glow; reset during vsync low must not yield a tick
    frame(24'h000008);
    frame(24'h000000);
    pix_expect("A glow before reset", 548, 246, 1'b1, 1'b1, AMBER);
    buttons = 24'h000008;
    do_reset();
    pix_expect("reset in vsync A", 548, 246, 1'b1, 1'b0, WHITE);
    pix_expect("reset in vsync A late", 548, 246, 1'b1, 1'b0, WHITE);
    frame(24'h000008);
    pix_expect("first tick after reset", 548, 246, 1'b1, 1'b1, GREEN);

    // Random frames and pixels against the model
    for (int f = 0; f < 25; f++) begin
      frame(NB'($urandom & $urandom));
      for (int s = 0; s < 24; s++) begin
        if (s == 10) buttons = NB'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          g  = $urandom_range(0, NB - 1);
          px = bx[g % 12] + $urandom_range(0, GSZ + 3) - 2;
          py = by[g % 12] + (g / 12) * PAD_Y_STEP + $urandom_range(0, GSZ + 3) - 2;
        end else begin
          px = $urandom_range(0, 1023);
          py = $urandom_range(0, 1023);
        end
        step(px, py, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
      end
    end
    repeat (2) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
